sfx_tone_sequencer: RTL
=======================

// Module: sfx_tone_sequencer
// PURPOSE
//  Game sound-effect source feeding the audio output mixer: on a hit/miss
//  trigger plays a short fixed melody of square-wave notes and drives a
//  signed 32-bit sample that the mixer adds to the left and right channels.
//  Replaces the switch-selected fixed tone. Sits between game FSM and mixer.
// PARAMETERS
//  AMPLITUDE   32'd10000000  peak magnitude of the square wave (signed)
//  NOTE_TICKS  5000000       note length in clocks (100 ms at 50 MHz)
//  GAP_TICKS   500000        silence between notes in clocks (10 ms)
//  DECAY_SHIFT 4             decay step = AMPLITUDE>>DECAY_SHIFT (SFX_DECAY_EN only)
// PORTS
//  CLOCK_50      in   1   system clock, 50 MHz
//  resetn        in   1   asynchronous active-low reset
//  trig_hit      in   1   1-cycle pulse: start the HIT melody
//  trig_miss     in   1   1-cycle pulse: start the MISS melody
//  sample_out    out  32  signed sample to the mixer, 0 when silent
//  busy          out  1   1 while a melody is playing (PLAY or GAP)
//  done          out  1   1-cycle pulse when the last note's gap ends
// BEHAVIOUR
//  Reset: state=IDLE, sample_out=0, busy=0, done=0, all counters 0, polarity=+.
//  Note ROM (half-period in clocks, 19 bits):
//   HIT  = 47801 (C5), 37936 (E5), 31888 (G5): 3 notes
//   MISS = 63776 (G4), 95554 (C4): 2 notes
//  FSM states: IDLE, PLAY, GAP.
//   IDLE: sample_out=0. Trigger -> PLAY, note_idx=0, seq latched.
//   PLAY: phase counter 0..half-1; at half-1 wraps to 0, polarity toggles.
//    sample_out = polarity ? +amp : -amp. Registered: 1-cycle latency from
//    the state/polarity change. dur counter 0..NOTE_TICKS-1; at end -> GAP.
//   GAP: sample_out=0 for GAP_TICKS clocks. Then, if note_idx is the last
//    note of seq -> IDLE with done=1 for exactly one cycle; else note_idx+1 -> PLAY.
//  Every PLAY entry resets phase=0, dur=0, polarity=+, amp=AMPLITUDE.
//  First non-zero sample appears 1 clock after the trigger is sampled.
//  busy=1 from the cycle after the trigger through the final GAP cycle.
//  trig_hit and trig_miss in the same cycle: HIT wins.
//  Trigger while busy: retrigger. Restart from note 0 of the new seq, with
//   no done pulse for the aborted melody.
//  Trigger in the same cycle as the final GAP end: retrigger wins, done=0.
//  resetn low at any time (mid-note included): immediate return to the reset
//   values, no glitch past 0.
//  Widths: +amp/-amp are 32-bit two's complement. -amp is computed as
//   (~amp + 1), never as a wider intermediate.
// CONFIGURATION
//  SFX_DECAY_EN defined: during PLAY, every 65536 clocks (16-bit prescaler,
//   cleared on PLAY entry) amp -= AMPLITUDE>>DECAY_SHIFT, saturating at 0.
//   GAP and IDLE leave amp untouched.
//  SFX_DECAY_EN undefined: amp == AMPLITUDE constantly. Prescaler and decay
//   logic are absent.
// TESTING
//  Reset release, no triggers for 1e6 clocks -> sample_out==0, busy==0, done==0.
//  trig_hit pulse -> +10000000 for 47801 clks, then -10000000, alternating;
//   3 notes + 3 gaps; done pulses once at 3*(NOTE_TICKS+GAP_TICKS)+1 clks.
//  trig_hit and trig_miss in the same cycle -> first half-period is 47801 (HIT).
//  trig_miss during HIT note 2 -> next cycle note_idx=0, half-period 63776,
//   no done for the HIT melody; one done after the 2 MISS notes.
//  resetn asserted mid-PLAY -> sample_out==0 and busy==0 within the same
//   cycle (async); no done pulse.
//  With SFX_DECAY_EN: |sample_out| after 65536*3 PLAY clks == 10000000-3*625000;
//   it reaches 0 after 16 steps and stays 0 for the rest of the note.

Source files
------------

// File: rtl/sfx_tone_sequencer_if.sv
// Trigger/sample bundle between the game FSM (master) and the tone sequencer (slave).
// The master issues one-cycle trigger pulses and receives the sample and the status flags.
interface sfx_tone_sequencer_if #(
    parameter int DATA_W = 32
);
    logic                     trig_hit;
    logic                     trig_miss;
    logic signed [DATA_W-1:0] sample_out;
    logic                     busy;
    logic                     done;

    modport master (
        output trig_hit,
        output trig_miss,
        input  sample_out,
        input  busy,
        input  done
    );

    modport slave (
        input  trig_hit,
        input  trig_miss,
        output sample_out,
        output busy,
        output done
    );
endinterface

// File: rtl/sfx_tone_sequencer.sv
// Sound-effect melody player: plays the HIT or MISS square-wave melody into the mixer sample.
// Optional feature macro SFX_DECAY_EN: stepwise amplitude decay during each note.
module sfx_tone_sequencer #(
    parameter int                       DATA_W      = 32,
    parameter logic signed [DATA_W-1:0] AMPLITUDE   = 32'sd10000000,
    parameter int                       NOTE_TICKS  = 5000000,
    parameter int                       GAP_TICKS   = 500000,
    parameter int                       DECAY_SHIFT = 4,
    // Divides every ROM half-period by 2**HALF_SHIFT; 0 keeps the real pitches.
    parameter int                       HALF_SHIFT  = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    sfx_tone_sequencer_if.slave   bus
);

    localparam int DUR_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int PH_W  = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_seq;      // 0 = HIT, 1 = MISS
    logic [1:0]               r_idx;
    logic [PH_W-1:0]          r_phase;
    logic [DUR_W-1:0]         r_dur;
    logic [GAP_W-1:0]         r_gap;
    logic                     r_pol;      // 1 = positive half
    logic                     r_busy;
    logic                     r_done;
    logic signed [DATA_W-1:0] r_sample_p1;

    logic                     w_trig;
    logic                     w_last;
    logic                     w_gap_end;
    logic                     w_play_entry;
    logic [PH_W-1:0]          w_half;
    logic signed [DATA_W-1:0] w_amp;

    function automatic logic [PH_W-1:0] note_half(input logic seq, input logic [1:0] idx);
        logic [PH_W-1:0] h;
        case ({seq, idx})
            3'b000:  h = 19'd47801;
            3'b001:  h = 19'd37936;
            3'b010:  h = 19'd31888;
            3'b100:  h = 19'd63776;
            3'b101:  h = 19'd95554;
            default: h = 19'd47801;
        endcase
        return h >> HALF_SHIFT;
    endfunction

    // Two's complement negation kept at the sample width, no wider intermediate.
    function automatic logic signed [DATA_W-1:0] neg_amp(input logic signed [DATA_W-1:0] a);
        return ~a + DATA_W'(1);
    endfunction

    assign w_trig       = bus.trig_hit | bus.trig_miss;
    assign w_half       = note_half(r_seq, r_idx);
    assign w_last       = (r_idx == (r_seq ? 2'd1 : 2'd2));
    assign w_gap_end    = (r_state == ST_GAP) && (r_gap == GAP_W'(GAP_TICKS - 1));
    assign w_play_entry = w_trig | (w_gap_end & ~w_last);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_seq   <= 1'b0;
            r_idx   <= '0;
            r_phase <= '0;
            r_dur   <= '0;
            r_gap   <= '0;
            r_pol   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_trig) begin
                // Retrigger from any state; HIT has priority over MISS.
                r_state <= ST_PLAY;
                r_seq   <= ~bus.trig_hit;
                r_idx   <= '0;
                r_phase <= '0;
                r_dur   <= '0;
                r_gap   <= '0;
                r_pol   <= 1'b1;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    ST_PLAY: begin
                        if (r_phase == w_half - 19'd1) begin
                            r_phase <= '0;
                            r_pol   <= ~r_pol;
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                        if (r_dur == DUR_W'(NOTE_TICKS - 1)) begin
                            r_state <= ST_GAP;
                            r_dur   <= '0;
                            r_gap   <= '0;
                        end else begin
                            r_dur <= r_dur + DUR_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (w_gap_end) begin
                            r_gap <= '0;
                            if (w_last) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_PLAY;
                                r_idx   <= r_idx + 2'd1;
                                r_phase <= '0;
                                r_dur   <= '0;
                                r_pol   <= 1'b1;
                            end
                        end else begin
                            r_gap <= r_gap + GAP_W'(1);
                        end
                    end
                    default: begin
                        r_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SFX_DECAY_EN
    localparam logic signed [DATA_W-1:0] DECAY_STEP = AMPLITUDE >>> DECAY_SHIFT;

    logic [15:0]              r_presc;
    logic signed [DATA_W-1:0] r_amp;

    function automatic logic signed [DATA_W-1:0] sat_sub(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
            r_amp   <= AMPLITUDE;
        end else if (w_play_entry) begin
            r_presc <= '0;
            r_amp   <= AMPLITUDE;
        end else if (r_state == ST_PLAY) begin
            r_presc <= r_presc + 16'd1;
            if (r_presc == 16'hFFFF) begin
                r_amp <= sat_sub(r_amp, DECAY_STEP);
            end
        end
    end

    assign w_amp = r_amp;
`else
    assign w_amp = AMPLITUDE;
`endif

    // Stage p1: sample registered from the current state and polarity.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sample_p1 <= '0;
        end else if (r_state == ST_PLAY) begin
            r_sample_p1 <= r_pol ? w_amp : neg_amp(w_amp);
        end else begin
            r_sample_p1 <= '0;
        end
    end

    assign bus.sample_out = r_sample_p1;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
